// File: rtl/cpu_pkg.sv
// Shared core definitions: M-extension op encodings, decode constants and the
// multiply/divide unit state type.
package cpu_pkg;

   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNCT7_W = 7;

   // funct3 encodings of the eight RV32M operations
   localparam logic [FUNCT3_W-1:0] F3_MUL    = 3'b000;
   localparam logic [FUNCT3_W-1:0] F3_MULH   = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_MULHSU = 3'b010;
   localparam logic [FUNCT3_W-1:0] F3_MULHU  = 3'b011;
   localparam logic [FUNCT3_W-1:0] F3_DIV    = 3'b100;
   localparam logic [FUNCT3_W-1:0] F3_DIVU   = 3'b101;
   localparam logic [FUNCT3_W-1:0] F3_REM    = 3'b110;
   localparam logic [FUNCT3_W-1:0] F3_REMU   = 3'b111;

   // Decode fields the controller matches to raise start
   localparam logic [OPCODE_W-1:0] OPCODE_OP     = 7'b0110011;
   localparam logic [FUNCT7_W-1:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle,
// sign fix-up in a final cycle, held result with a one-cycle done pulse.
module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                kill,
   input  logic [FUNCT3_W-1:0] funct3,
   input  logic [XLEN-1:0]     ReadData1,
   input  logic [XLEN-1:0]     ReadData2,
   output logic                busy,
   output logic                done,
   output logic [XLEN-1:0]     result
);

   localparam int unsigned CW = $clog2(XLEN + 1);
   localparam int unsigned PW = 2 * XLEN;

   md_state_t state, state_next;
   logic busy_next, done_next;

   logic [CW-1:0]       count;
   logic [FUNCT3_W-1:0] op;
   logic                sign1, sign2;
   logic [XLEN-1:0]     opa, opb;
   logic [PW-1:0]       acc;
   logic [XLEN-1:0]     quo;
   logic [XLEN-1:0]     rem;

   // Input decode
   logic            sgn1_in, sgn2_in, neg1_in, neg2_in;
   logic [XLEN-1:0] abs1_in, abs2_in;
   logic            div_zero, div_ovf, special, accept;
   logic [XLEN-1:0] special_result;

   // Iteration datapath
   logic [XLEN:0]   mul_sum;
   logic [PW-1:0]   acc_step;
   logic [XLEN:0]   div_shift, div_diff;
   logic            div_take;
   logic [XLEN-1:0] rem_step, quo_step;

   // Sign fix-up
   logic [PW-1:0]   prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix, fix_result;

   // Operand signedness, magnitudes and the bypass special cases
   always_comb begin
      sgn1_in = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
      sgn2_in = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
      neg1_in = sgn1_in && ReadData1[XLEN-1];
      neg2_in = sgn2_in && ReadData2[XLEN-1];
      abs1_in = neg1_in ? XLEN'(-ReadData1) : ReadData1;
      abs2_in = neg2_in ? XLEN'(-ReadData2) : ReadData2;
      div_zero = funct3[2] && (ReadData2 == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (ReadData1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (ReadData2 == '1);
      special  = div_zero || div_ovf;
      if (div_zero)
         special_result = funct3[1] ? ReadData1 : '1;
      else
         special_result = funct3[1] ? '0 : ReadData1;
      accept = start && !kill && ((state == MD_IDLE) || (state == MD_DONE));
   end

   // One shift-add multiply step and one restoring divide step
   always_comb begin
      mul_sum   = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
      acc_step  = {mul_sum, acc[XLEN-1:1]};
      div_shift = {rem, quo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      div_take  = !div_diff[XLEN];
      rem_step  = div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      quo_step  = {quo[XLEN-2:0], div_take};
   end

   // Apply result signs and pick the requested half/quantity
   always_comb begin
      prod_fix = (sign1 ^ sign2) ? PW'(-acc) : acc;
      quo_fix  = (sign1 ^ sign2) ? XLEN'(-quo) : quo;
      rem_fix  = sign1 ? XLEN'(-rem) : rem;
      case (op)
         F3_MUL:                     fix_result = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[PW-1:XLEN];
         F3_DIV, F3_DIVU:            fix_result = quo_fix;
         default:                    fix_result = rem_fix;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; kill always wins over start
   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE, MD_DONE: begin
            if (kill || !start) state_next = MD_IDLE;
            else if (special)   state_next = MD_DONE;
            else                state_next = MD_CALC;
         end
         MD_CALC: begin
            if (kill)                    state_next = MD_IDLE;
            else if (count == CW'(1))    state_next = MD_FIX;
         end
         MD_FIX: begin
            if (kill) state_next = MD_IDLE;
            else      state_next = MD_DONE;
         end
         default: state_next = MD_IDLE;
      endcase
   end

   // Status outputs for the coming state
   always_comb begin
      busy_next = 1'b0;
      done_next = 1'b0;
      if ((state_next == MD_CALC) || (state_next == MD_FIX)) busy_next = 1'b1;
      if (state_next == MD_DONE)                             done_next = 1'b1;
   end

   // Registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= done_next;
      end
   end

   // Operand latch, iteration accumulators and result register
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         op     <= '0;
         sign1  <= 1'b0;
         sign2  <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         quo    <= '0;
         rem    <= '0;
         result <= '0;
      end else if (accept) begin
         count <= CW'(XLEN);
         op    <= funct3;
         sign1 <= neg1_in;
         sign2 <= neg2_in;
         opa   <= abs1_in;
         opb   <= abs2_in;
         acc   <= {{XLEN{1'b0}}, abs2_in};
         quo   <= abs1_in;
         rem   <= '0;
         if (special) result <= special_result;
      end else if ((state == MD_CALC) && !kill) begin
         count <= count - CW'(1);
         if (op[2]) begin
            rem <= rem_step;
            quo <= quo_step;
         end else begin
            acc <= acc_step;
         end
      end else if ((state == MD_FIX) && !kill) begin
         result <= fix_result;
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts rs1/rs2 plus funct3 on a start pulse, computes one bit per cycle, and returns a held result with a one-cycle done pulse.
- The core stalls on busy.

Parameters:
- XLEN, 32, operand and result width in bits (≥ 8, even).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- kill  input  1  abort in-flight operation (pipeline flush).
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ReadData1  input  XLEN  rs1 operand.
- ReadData2  input  XLEN  rs2 operand.
- busy  output  1  high while an operation is in flight (state CALC or FIX).
- done  output  1  one-cycle pulse, result valid.
- result  output  XLEN  result; held stable from done until next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; counter, accumulators and latched op cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch funct3, operand signs, and absolute values. An operand is signed for MULH/DIV/REM (both), and for MULHSU (rs1 only).
  - Set count=XLEN and go to CALC.
  - Special cases bypass CALC and go to DONE directly, result computed from the inputs:
    - divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
    - signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): DIV → rs1; REM → 0.
- DONE with start=0: go to IDLE. done is high only in DONE.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, XLEN+1-bit partial remainder.
  - count decrements each cycle; after XLEN cycles go to FIX.
- FIX (1 cycle):
  - Apply sign: product negated (2·XLEN wide) when sign1^sign2 (MUL/MULH/MULHU), or when sign1 (MULHSU); quotient negated when sign1^sign2; remainder negated when sign1.
  - Select the low XLEN bits (MUL) or high XLEN bits (MULH*), quotient (DIV*) or remainder (REM*).
  - Register into result; go to DONE.
- Latency, start accepted at edge 0:
  - normal: done high in cycle XLEN+2 (34 for XLEN=32).
  - special case: done high in cycle 1.
- Back-to-back: start asserted while done=1 is accepted; done drops next cycle.
- start during CALC/FIX: ignored, no effect on the in-flight op.
- kill: in CALC or FIX, go to IDLE next edge. done is not asserted and result keeps its previous value. kill in IDLE/DONE takes priority over start (request dropped).
- rst mid-operation: full reset per above, same cycle semantics as kill plus result=0.
- All arithmetic is modulo 2^XLEN (2^(2·XLEN) internally); no exceptions, no overflow flags.

Decomposition:
- Shared package cpu_pkg:
  - funct3 constants for the eight M-extension ops.
  - OPCODE_OP and FUNCT7_MULDIV (0000001) used by Controller to raise start.
  - State enum for this FSM.
- No sub-module: a single FSM plus two datapath accumulators fits comfortably; a separate negate/abs helper is not worth a module boundary.

Test Plan:
- MUL 7×(-3) (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB, done at cycle 34, busy high cycles 1–33.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF:
  - MULH → 0x00000000
  - MULHSU → 0x80000000
  - MULHU → 0x7FFFFFFF
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 0x00000001.
- Special cases, done in cycle 1, busy never high:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- kill at cycle 10 of a MUL → IDLE next cycle, no done pulse, result unchanged; start during CALC ignored; back-to-back start on done cycle accepted.
- rst asserted mid-divide → busy=0, done=0, result=0 the following cycle; next op completes correctly.
